// File: rtl/sig_tdm_tx.sv
// TDM serial transmitter: shifts a parallel word out LSB first, one bit per clock,
// tagging each bit with its slot address, a frame sync and a frame-done strobe.
module sig_tdm_tx #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned GAP    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              sout,
  output logic [ADDR_W-1:0] slot_addr,
  output logic              sync,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned       GCNT_W    = 4;
  localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(WIDTH - 1);
  localparam logic [GCNT_W-1:0] GAP_INIT  = (GAP > 0) ? GCNT_W'(GAP - 1) : '0;

  typedef enum logic [1:0] {IDLE, SEND, GAPW} state_t;

  state_t             state;
  logic [WIDTH-1:0]   shreg;
  logic [GCNT_W-1:0]  gcnt;
  logic               hs;

  // Ready in IDLE, on the last slot when frames run back to back, and on the last gap cycle
  always_comb begin
    din_ready = 1'b0;
    case (state)
      IDLE:    din_ready = 1'b1;
      SEND:    din_ready = (GAP == 0) && (slot_addr == LAST_SLOT);
      GAPW:    din_ready = (gcnt == '0);
      default: din_ready = 1'b0;
    endcase
  end

  assign hs = din_valid & din_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      gcnt       <= '0;
      sout       <= 1'b0;
      slot_addr  <= '0;
      sync       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      sync       <= 1'b0;
      frame_done <= 1'b0;
      if (hs) begin
        // Bit 0 goes out immediately; the rest wait in the shift register
        state     <= SEND;
        shreg     <= din >> 1;
        sout      <= din[0];
        slot_addr <= '0;
        sync      <= 1'b1;
        busy      <= 1'b1;
      end else begin
        case (state)
          SEND: begin
            if (slot_addr != LAST_SLOT) begin
              slot_addr  <= slot_addr + ADDR_W'(1);
              sout       <= shreg[0];
              shreg      <= shreg >> 1;
              frame_done <= ((slot_addr + ADDR_W'(1)) == LAST_SLOT);
            end else if (GAP != 0) begin
              state     <= GAPW;
              gcnt      <= GAP_INIT;
              sout      <= 1'b0;
              slot_addr <= '0;
            end else begin
              state     <= IDLE;
              sout      <= 1'b0;
              slot_addr <= '0;
              busy      <= 1'b0;
            end
          end
          GAPW: begin
            if (gcnt != '0) begin
              gcnt <= gcnt - GCNT_W'(1);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state     <= IDLE;
            sout      <= 1'b0;
            slot_addr <= '0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sig_tdm_tx.sv
// Bench for sig_tdm_tx: GAP=0 and GAP=2 instances share one stimulus stream and are
// compared every cycle against a slot-position reference model.
module tb_sig_tdm_tx;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned ADDR_W = 2;
  localparam int UNK = -2;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             din_valid;

  logic              din_ready [2];
  logic              sout      [2];
  logic [ADDR_W-1:0] slot_addr [2];
  logic              sync      [2];
  logic              busy      [2];
  logic              frame_done[2];

  sig_tdm_tx #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .GAP(0)) u_g0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready[0]),
    .sout(sout[0]), .slot_addr(slot_addr[0]), .sync(sync[0]), .busy(busy[0]),
    .frame_done(frame_done[0])
  );

  sig_tdm_tx #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .GAP(2)) u_g2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready[1]),
    .sout(sout[1]), .slot_addr(slot_addr[1]), .sync(sync[1]), .busy(busy[1]),
    .frame_done(frame_done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: position within the current frame+gap window, -1 when idle
  int               pos  [2] = '{UNK, UNK};
  logic [WIDTH-1:0] word [2];
  int               gapv [2] = '{0, 2};
  logic             last_sout0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check outputs against the model, drive inputs, then advance the model
  task automatic cycle(input logic r, input logic v, input logic [WIDTH-1:0] d);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (pos[i] != UNK) begin
        int  p;
        bit  in_frame;
        string pre;
        p = pos[i];
        in_frame = (p >= 0) && (p < int'(WIDTH));
        pre = $sformatf("g%0d", gapv[i]);
        check({pre, "_sout"},  32'(sout[i]),       in_frame ? 32'(word[i][p]) : 32'd0);
        check({pre, "_slot"},  32'(slot_addr[i]),  in_frame ? 32'(p) : 32'd0);
        check({pre, "_sync"},  32'(sync[i]),       32'(p == 0));
        check({pre, "_busy"},  32'(busy[i]),       32'(p >= 0));
        check({pre, "_fdone"}, 32'(frame_done[i]), 32'(p == int'(WIDTH) - 1));
        check({pre, "_ready"}, 32'(din_ready[i]),
              32'((p < 0) || (p == int'(WIDTH) + gapv[i] - 1)));
      end
    end
    last_sout0 = sout[0];
    rst = r;
    din_valid = v;
    din = d;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      bit rdy;
      rdy = (pos[i] < 0) || (pos[i] == int'(WIDTH) + gapv[i] - 1);
      if (r) pos[i] = -1;
      else if (pos[i] == UNK) pos[i] = UNK;
      else if (v && rdy) begin
        word[i] = d;
        pos[i] = 0;
      end else if (pos[i] >= 0) begin
        pos[i]++;
        if (pos[i] == int'(WIDTH) + gapv[i]) pos[i] = -1;
      end
    end
  endtask

  initial begin
    logic [7:0] seq;
    rst = 1'b1;
    din_valid = 1'b0;
    din = '0;

    // Reset, including a handshake attempt that reset must drop
    cycle(1'b1, 1'b0, 4'h0);
    cycle(1'b1, 1'b1, 4'hF);
    cycle(1'b0, 1'b0, 4'h0);

    // Reset asserted for two cycles during slot 1 of a frame
    cycle(1'b0, 1'b1, 4'b1011);
    cycle(1'b0, 1'b0, 4'b1011);
    cycle(1'b1, 1'b0, 4'b1011);
    cycle(1'b1, 1'b0, 4'b1011);
    repeat (3) cycle(1'b0, 1'b0, 4'h0);

    // Single frame with a one-cycle valid
    cycle(1'b0, 1'b1, 4'b0010);
    repeat (8) cycle(1'b0, 1'b0, 4'b0010);

    // Back to back: record eight consecutive sout bits from the GAP=0 instance
    cycle(1'b0, 1'b1, 4'b1101);
    seq = '0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, i < 4, 4'b0110);
      seq[i] = last_sout0;
    end
    check("b2b_stream", 32'(seq), 32'h6D);
    repeat (8) cycle(1'b0, 1'b0, 4'h0);

    // Valid held across two words; exercises the gap window on the GAP=2 instance
    cycle(1'b0, 1'b1, 4'b1001);
    repeat (9) cycle(1'b0, 1'b1, 4'b0101);
    repeat (8) cycle(1'b0, 1'b0, 4'h0);

    // din changing mid-frame must not affect the word already captured
    cycle(1'b0, 1'b1, 4'b0010);
    cycle(1'b0, 1'b0, 4'b0010);
    repeat (6) cycle(1'b0, 1'b0, 4'b1111);

    // Idle with valid low
    repeat (10) cycle(1'b0, 1'b0, 4'($urandom));

    // Randomized traffic with occasional resets
    repeat (3000) begin
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, 4'($urandom));
    end
    repeat (10) cycle(1'b0, 1'b0, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sig_tdm_tx.md
# sig_tdm_tx

Time-division-multiplexed transmitter for the signal-router path. Accepts a WIDTH-bit parallel word through a valid/ready handshake and drives its bits one per clock onto a single serial line. Each bit is accompanied by its slot address and a frame sync, so a downstream demux/router can steer each bit back to its own output line. It is the sending end of the single-wire link feeding the router's demux side.

## Interface

- WIDTH, default 4: number of parallel lines per frame (power of two, 2..16).
- ADDR_W, default 2: slot address width; must equal log2(WIDTH).
- GAP, default 0: idle slots inserted after each frame (0..15).

- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  parallel word; bit n is line n+1.
- din_valid  input  1  din is presented.
- din_ready  output  1  block can accept a word this cycle; combinational from state.
- sout  output  WIDTH=1  serial data bit; registered.
- slot_addr  output  ADDR_W  index of the bit currently on sout; registered.
- sync  output  1  high during slot 0 of every frame; registered.
- busy  output  1  frame or gap in progress; registered.
- frame_done  output  1  high during the last slot (WIDTH-1) of a frame; registered.

## Operation

- FSM states: IDLE, SEND, GAPW.
- IDLE: din_ready=1. On din_valid&din_ready, capture din into the shift register and go to SEND with slot=0.
- SEND: sout=captured[slot], LSB first. slot_addr=slot. slot increments by 1 each cycle.
- At slot WIDTH-1 with GAP=0: din_ready=1. If din_valid, load a new word and restart at slot 0 with no bubble. Otherwise go to IDLE.
- At slot WIDTH-1 with GAP>0: go to GAPW with gap counter = GAP-1.
- GAPW: sout=0, sync=0, slot_addr=0, busy=1. Counter decrements each cycle.
- In the last GAPW cycle (counter=0), din_ready=1. A handshake then goes to SEND slot 0; otherwise go to IDLE.
- din is sampled only on the handshake edge. Changes to din during SEND or GAPW are ignored.
- din_valid while din_ready=0 is ignored; no error is flagged and no word is queued.
- Slot counter is ADDR_W bits and wraps from WIDTH-1 to 0 only via a new load.
- Reset, at any time including mid-frame: next state IDLE. Outputs become sout=0, slot_addr=0, sync=0, busy=0, frame_done=0, and din_ready=1. The partial frame is abandoned and no frame_done is emitted for it.
- rst takes priority over a simultaneous handshake; the word is dropped.

## Timing

- Handshake edge E0 puts bit 0 on the outputs: sout=din[0], slot_addr=0, sync=1, busy=1. Latency is one cycle from acceptance.
- After edge E0+k (k<WIDTH): sout=din[k] and slot_addr=k.
- frame_done=1 for exactly one cycle, coinciding with slot_addr=WIDTH-1.
- A frame occupies WIDTH cycles, followed by GAP idle cycles.
- Back-to-back throughput: one word per WIDTH+GAP cycles.
- Returning to IDLE without a new word: the cycle after the last slot (or last gap cycle) shows sout=0, sync=0, busy=0, slot_addr=0.

## Test plan

- Reset: assert rst for 2 cycles during slot 1 of a frame with din=4'b1011. Next cycle shows all outputs 0 and din_ready=1. frame_done never pulses.
- Single frame, GAP=0, din=4'b0010 with a 1-cycle valid. Over slots 0..3, sout is 0,1,0,0 and slot_addr is 0,1,2,3. sync is high at slot 0 only and frame_done at slot 3. Then idle with busy=0.
- Back-to-back, GAP=0, din_valid held with 4'b1101 then 4'b0110. sout is 1,0,1,1,0,1,1,0 over 8 contiguous cycles. sync is high at cycles 0 and 4, and frame_done at cycles 3 and 7.
- GAP=2, din_valid held with two words. Exactly 2 cycles of sout=0, busy=1 separate the frames. din_ready is high only in the second gap cycle. The second frame's sync appears on the cycle after it.
- Mid-frame din change: load 4'b0010, then drive din=4'b1111 from slot 1 onward. sout stays 0,1,0,0.
- din_valid held low in IDLE for 10 cycles: busy=0, sync=0 and din_ready=1 throughout.
